// File: rtl/absorb_pad_if.sv
// Bundle of the message-in and block-out handshakes of the absorb/pad stage.
// The slave modport is the stage itself; the master modport is its driver/consumer.
interface absorb_pad_if #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
);
  logic                start;
  logic [1:0]          mode_in;
  logic [31:0]         output_size_in;
  logic [W-1:0]        data_in;
  logic                data_valid;
  logic                data_last;
  logic [3:0]          data_bytes;
  logic                data_ready;
  logic [RATE_MAX-1:0] block_out;
  logic                block_valid;
  logic                block_ready;
  logic                block_last;
  logic [1:0]          mode_out;
  logic [31:0]         output_size_out;

  modport slave (
    input  start, mode_in, output_size_in, data_in, data_valid, data_last,
           data_bytes, block_ready,
    output data_ready, block_out, block_valid, block_last, mode_out,
           output_size_out
  );

  modport master (
    output start, mode_in, output_size_in, data_in, data_valid, data_last,
           data_bytes, block_ready,
    input  data_ready, block_out, block_valid, block_last, mode_out,
           output_size_out
  );
endinterface

// File: rtl/absorb_pad_stage.sv
// Collects message words into a rate-sized block and applies SHAKE padding
// (0x1F domain byte, 0x80 final bit), emitting one block at a time downstream.
module absorb_pad_stage #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
) (
  input  logic         clk,
  input  logic         rst,
  absorb_pad_if.slave  bus
);
  localparam int NB = W / 8;
  localparam int NW = RATE_MAX / W;

  typedef enum logic [1:0] {IDLE, ABSORB, PADBLK, FULL} state_e;

  state_e              state_q, state_d;
  logic [RATE_MAX-1:0] buf_q, buf_d;
  logic [4:0]          idx_q, idx_d;
  logic                last_q, last_d;
  logic                pend_q, pend_d;
  logic [1:0]          mode_q, mode_d;
  logic [31:0]         osize_q, osize_d;

  logic [4:0]          r_last;
  logic                full_word;
  logic [W-1:0]        word_w;
  logic                wr_word, pad_next, set_head, set_end;

  // Only 2'b01 selects SHAKE256; every other mode code absorbs at the SHAKE128 rate.
  assign r_last    = (mode_q == 2'b01) ? 5'd16 : 5'd20;
  assign full_word = !bus.data_last || (bus.data_bytes >= 4'(NB));

  // Last word: drop bytes past data_bytes and drop the domain byte right after the data.
  always_comb begin
    word_w = bus.data_in;
    if (bus.data_last) begin
      for (int k = 0; k < NB; k++) begin
        if (4'(k) >= bus.data_bytes) word_w[8*k +: 8] = 8'h00;
        if (4'(k) == bus.data_bytes) word_w[8*k +: 8] = 8'h1F;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    last_d   = last_q;
    pend_d   = pend_q;
    mode_d   = mode_q;
    osize_d  = osize_q;
    wr_word  = 1'b0;
    pad_next = 1'b0;
    set_head = 1'b0;
    set_end  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode_in;
          osize_d = bus.output_size_in;
          buf_d   = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = ABSORB;
        end
      end
      ABSORB: begin
        if (bus.data_valid) begin
          wr_word = 1'b1;
          if (bus.data_last) begin
            state_d = FULL;
            if (!full_word || idx_q != r_last) begin
              pad_next = full_word;
              set_end  = 1'b1;
              last_d   = 1'b1;
            end else begin
              // Message filled the block exactly: padding needs a block of its own.
              last_d = 1'b0;
              pend_d = 1'b1;
            end
          end else if (idx_q == r_last) begin
            last_d  = 1'b0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      PADBLK: begin
        set_head = 1'b1;
        set_end  = 1'b1;
        last_d   = 1'b1;
        pend_d   = 1'b0;
        state_d  = FULL;
      end
      FULL: begin
        if (bus.block_ready) begin
          buf_d   = '0;
          idx_d   = '0;
          state_d = pend_q ? PADBLK : (last_q ? IDLE : ABSORB);
        end
      end
      default: state_d = IDLE;
    endcase

    if (set_head) buf_d[RATE_MAX-W +: 8] = 8'h1F;
    for (int j = 0; j < NW; j++) begin
      if (wr_word && idx_q == 5'(j))
        buf_d[RATE_MAX-W*(j+1) +: W] = word_w;
      if (pad_next && (idx_q + 5'd1) == 5'(j))
        buf_d[RATE_MAX-W*(j+1) +: 8] = 8'h1F;
      // OR rather than assign so a coinciding 0x1F merges into 0x9F.
      if (set_end && r_last == 5'(j))
        buf_d[RATE_MAX-W*j-8 +: 8] = buf_d[RATE_MAX-W*j-8 +: 8] | 8'h80;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      mode_q  <= '0;
      osize_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      osize_q <= osize_d;
    end
  end

  assign bus.data_ready      = (state_q == ABSORB);
  assign bus.block_valid     = (state_q == FULL);
  assign bus.block_last      = (state_q == FULL) && last_q;
  assign bus.block_out       = buf_q;
  assign bus.mode_out        = mode_q;
  assign bus.output_size_out = osize_q;
endmodule

// File: doc/absorb_pad_stage.md
ABSORB_PAD_STAGE -- requirements
Module: absorb_pad_stage

Interface
REQ-001 SHALL have parameter W, default 64, the input word width in bits.
REQ-002 SHALL have parameter RATE_MAX, default 1344, the SHAKE128 rate and the block_out width in bits.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 start  in  1  begin a message; sampled only in IDLE.
REQ-006 mode_in  in  2  2'b00 = SHAKE128 (21 words per block), 2'b01 = SHAKE256 (17 words per block); other values SHALL be treated as SHAKE128.
REQ-007 output_size_in  in  32  requested output length in bits; captured with start.
REQ-008 data_in  in  W  message word; byte k = bits [8k+7:8k].
REQ-009 data_valid  in  1  data_in is valid.
REQ-010 data_last  in  1  this is the final message word.
REQ-011 data_bytes  in  4  number of valid bytes in the last word (0..8); ignored unless data_last is high.
REQ-012 data_ready  out  1  word accepted when data_valid && data_ready.
REQ-013 block_out  out  RATE_MAX  padded block; word j at bits [RATE_MAX-1-W*j -: W]; unused SHAKE256 words are zero.
REQ-014 block_valid  out  1  block_out is complete and held stable.
REQ-015 block_ready  in  1  downstream permute stage consumes the block on block_valid && block_ready.
REQ-016 block_last  out  1  qualifies block_out as the final block of the message.
REQ-017 mode_out  out  2, output_size_out  out  32  captured configuration, stable from start until the next start.

Function
REQ-018 SHALL implement states IDLE, ABSORB, PADBLK and FULL.
REQ-019 IDLE: data_ready = 0; start = 1 SHALL capture mode_in and output_size_in, clear the buffer and the word index, and move to ABSORB.
REQ-020 ABSORB: data_ready = 1; each accepted word SHALL be written to buffer word idx, and idx SHALL increment.
REQ-021 Buffer full, non-last: an accepted non-last word with idx = R-1 SHALL move to FULL with block_last = 0.
REQ-022 Last word, room to pad: an accepted last word with data_bytes < 8 SHALL write 0x1F at (idx, data_bytes), OR 0x80 into (R-1, byte 7), and move to FULL with block_last = 1.
REQ-023 Last word, full, not at end: when data_bytes = 8 and idx < R-1, the 0x1F byte SHALL go to (idx+1, byte 0), followed by the same 0x80 and the move to FULL with block_last = 1.
REQ-024 Last word completes the block: when data_bytes = 8 and idx = R-1, the block SHALL go to FULL with block_last = 0 and PADBLK pending.
  - After that handshake, PADBLK SHALL build a pad-only block: 0x1F at (0,0) and 0x80 at (R-1,7).
  - The pad-only block SHALL be presented in FULL with block_last = 1 on the cycle after PADBLK.
REQ-025 Collision: if 0x1F and 0x80 land in the same byte, that byte SHALL be 0x9F.
REQ-026 Invalid bytes: bytes at or above data_bytes in the last word SHALL be written as zero, except the pad byte.
REQ-027 FULL: block_valid = 1 and data_ready = 0; block_out, block_last and mode_out SHALL be stable until the handshake.
REQ-028 FULL handshake: the buffer SHALL clear and idx reset to 0, then go to ABSORB if more data is expected, to PADBLK if a pad-only block is pending, else to IDLE.
REQ-029 Latency: block_valid SHALL rise exactly one cycle after the accepting edge of the completing word.
REQ-030 Throughput: one block per R+1 cycles SHALL be sustained with block_ready held high.
REQ-031 Ignored start: start outside IDLE SHALL be ignored; data_valid outside ABSORB SHALL be ignored.
REQ-032 Index counter: idx SHALL be 5 bits and SHALL never exceed R-1.

Reset
REQ-033 rst SHALL force IDLE and zero the buffer and idx; block_valid, block_last, data_ready, mode_out and output_size_out SHALL reset to 0.
REQ-034 rst mid-message or in FULL SHALL discard the partial block with no handshake; rst SHALL take priority over all other inputs.

Verification
REQ-035 SHAKE128, empty message: one word with data_last = 1, data_bytes = 0 -> one block with word0 = 0x..1F, word20 byte7 = 0x80, block_last = 1.
REQ-036 SHAKE256, 17 full words with the last flagged -> block 1 has block_last = 0, then block 2 has 0x1F at (0,0), 0x80 at (16,7), block_last = 1.
REQ-037 SHAKE256, 16 words with the 16th data_bytes = 8 -> 0x1F at (16,0) and 0x80 at (16,7) in one block.
REQ-038 SHAKE128, 21 words with the last data_bytes = 7 -> byte (20,7) = 0x9F.
REQ-039 Hold block_ready = 0 for 10 cycles in FULL -> block_out stable, data_ready = 0; release -> exactly one handshake.
REQ-040 Assert rst after 5 words of a message, then start a new message -> no stale data in its first block; outputs zero during reset.
